// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits byte/half/word CPU accesses into single-byte
// memory transactions, with a per-byte read timeout and sign/zero extension of loads.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic        mem_ready
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  state_t        r_state;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_data;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_idx_nxt;
  logic          w_last;
  logic [31:0]   w_raw;
  logic [31:0]   w_ext;

  // w_raw merges the byte arriving this cycle so the final result can be
  // registered on the same edge that captures the last byte.
  always_comb begin
    w_idx_nxt = r_idx + 2'd1;
    unique case (r_size)
      2'b00:   w_last = (r_idx == 2'd0);
      2'b01:   w_last = (r_idx == 2'd1);
      default: w_last = (r_idx == 2'd3);
    endcase
    w_raw = r_data;
    w_raw[8*r_idx +: 8] = mem_rdata;
    unique case (r_size)
      2'b00:   w_ext = r_signed ? {{24{w_raw[7]}}, w_raw[7:0]}   : {24'd0, w_raw[7:0]};
      2'b01:   w_ext = r_signed ? {{16{w_raw[15]}}, w_raw[15:0]} : {16'd0, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_data    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            req_ready <= 1'b0;
            if (req_size == 2'b11) begin
              r_state    <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_write) begin
              r_state      <= WR;
              mem_write_en <= 1'b1;
              mem_addr     <= req_addr;
              mem_wdata    <= req_wdata[7:0];
            end else begin
              r_state     <= RD;
              mem_read_en <= 1'b1;
              mem_addr    <= req_addr;
            end
          end
        end
        WR: begin
          if (w_last) begin
            r_state      <= DONE;
            resp_valid   <= 1'b1;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
          end else begin
            r_idx     <= w_idx_nxt;
            mem_addr  <= r_addr + 32'(w_idx_nxt);
            mem_wdata <= r_wdata[8*w_idx_nxt +: 8];
          end
        end
        RD: begin
          if (mem_ready) begin
            r_data[8*r_idx +: 8] <= mem_rdata;
            r_cnt <= '0;
            if (w_last) begin
              r_state     <= DONE;
              resp_valid  <= 1'b1;
              resp_rdata  <= w_ext;
              mem_read_en <= 1'b0;
              mem_addr    <= '0;
            end else begin
              r_idx    <= w_idx_nxt;
              mem_addr <= r_addr + 32'(w_idx_nxt);
            end
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state     <= ERR;
            resp_valid  <= 1'b1;
            resp_err    <= 1'b1;
            mem_read_en <= 1'b0;
            mem_addr    <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE, ERR: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a transaction-level model predicts the full
// per-cycle output trace of each request, and a byte memory answers read requests.
module tb_load_store_unit;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_read_en, mem_write_en, mem_ready;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_ready(mem_ready)
  );

  typedef struct packed {
    logic        rdy, rv, rerr;
    logic [31:0] rdata, addr;
    logic [7:0]  wdata;
    logic        ren, wen;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        act;
  int unsigned vectors = 0, miscompares = 0;
  int unsigned cyc = 0, nresp = 0, resp_cyc = 0;
  logic [31:0] resp_data;
  logic        resp_e;
  logic        chk_en = 1'b0;

  always_comb act = {req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata,
                     mem_read_en, mem_write_en};

  // Byte memory: unwritten bytes read as the low address byte; re-reading the
  // last served address with no write in between never answers.
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] last_addr = '0;
  logic        last_v = 1'b0;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0];
  endfunction

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (mem_write_en) begin
      mem[mem_addr] = mem_wdata;
      last_v = 1'b0;
    end
    if (mem_read_en && !mem_ready && !(last_v && last_addr == mem_addr)) begin
      mem_ready <= 1'b1;
      mem_rdata <= mem_rd(mem_addr);
      last_addr = mem_addr;
      last_v    = 1'b1;
    end
  end

  function automatic obs_t busy();
    obs_t o = '0;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.rdy = 1'b1;
    return o;
  endfunction

  // Pushes the expected output of every cycle from the one after acceptance up to
  // and including the response cycle; returns how many cycles that is.
  function automatic int unsigned predict(input logic w, input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] wd);
    obs_t        o;
    int unsigned n, len = 0;
    logic [31:0] val = '0, ai, la = last_addr;
    logic        lv = last_v;
    if (sz == 2'b11) begin
      o = busy(); o.rv = 1'b1; o.rerr = 1'b1;
      exp_q.push_back(o);
      return 1;
    end
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (w) begin
      for (int unsigned i = 0; i < n; i++) begin
        o = busy(); o.wen = 1'b1; o.addr = a + 32'(i); o.wdata = wd[8*i +: 8];
        exp_q.push_back(o);
      end
      o = busy(); o.rv = 1'b1;
      exp_q.push_back(o);
      return n + 1;
    end
    for (int unsigned i = 0; i < n; i++) begin
      ai = a + 32'(i);
      o = busy(); o.ren = 1'b1; o.addr = ai;
      if (lv && ai == la) begin
        for (int unsigned k = 0; k < TIMEOUT; k++) exp_q.push_back(o);
        o = busy(); o.rv = 1'b1; o.rerr = 1'b1;
        exp_q.push_back(o);
        return len + TIMEOUT + 1;
      end
      exp_q.push_back(o);
      exp_q.push_back(o);
      len += 2;
      val |= 32'(mem_rd(ai)) << (8*i);
      la = ai;
      lv = 1'b1;
    end
    if (sg && n < 4 && val[8*n-1]) val |= ~((32'd1 << (8*n)) - 32'd1);
    o = busy(); o.rv = 1'b1; o.rdata = val;
    exp_q.push_back(o);
    return len + 1;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    cyc++;
    if (chk_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_obs();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL trace cyc %0d: got rdy=%b rv=%b err=%b rdata=%h addr=%h wdata=%h ren=%b wen=%b, want rdy=%b rv=%b err=%b rdata=%h addr=%h wdata=%h ren=%b wen=%b",
                 cyc, act.rdy, act.rv, act.rerr, act.rdata, act.addr, act.wdata, act.ren, act.wen,
                 e.rdy, e.rv, e.rerr, e.rdata, e.addr, e.wdata, e.ren, e.wen);
      end
      if (resp_valid) begin
        nresp++;
        resp_cyc  = cyc;
        resp_data = resp_rdata;
        resp_e    = resp_err;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic junk();
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output int unsigned e0, output int unsigned len);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    e0  = cyc;
    len = predict(w, sz, sg, a, wd);
    #1 req_valid = 1'b0;
    junk();
  endtask

  // Busy cycles carry random request noise that the unit must ignore.
  task automatic run(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] wd, output int unsigned e0);
    int unsigned len;
    issue(w, sz, sg, a, wd, e0, len);
    repeat (len) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      junk();
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    int unsigned e0, len, n0;
    logic [1:0]  sz;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0;
    junk();
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 32'(act), 32'(idle_obs()));
    check("reset_rdata", act.rdata, 32'd0);

    for (int unsigned i = 0; i < 256; i++) mem[32'(i)] = 8'(i);

    run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, e0); idle(1);
    check("store_word_latency", resp_cyc - e0 - 1, 32'd4);
    check("store_word_err", 32'(resp_e), 32'd0);
    run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e0); idle(1);
    check("load_word_data", resp_data, 32'hDEADBEEF);
    check("load_word_latency", resp_cyc - e0 - 1, 32'd8);
    run(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, e0); idle(1);
    check("signed_half_data", resp_data, 32'hFFFF8180);
    run(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, e0); idle(1);
    check("byte_7f_data", resp_data, 32'h0000007F);
    run(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, e0); idle(1);
    check("repeat_read_err", 32'(resp_e), 32'd1);
    check("repeat_read_data", resp_data, 32'd0);
    check("repeat_read_latency", resp_cyc - e0 - 1, TIMEOUT);

    // Reset lands on the edge after byte 1 of a word load was captured.
    n0 = nresp;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, e0, len);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    idle(3);
    check("reset_drops_response", nresp - n0, 32'd0);
    run(1'b1, 2'b00, 1'b0, 32'h40, 32'h000000A5, e0); idle(1);
    check("post_reset_store_latency", resp_cyc - e0 - 1, 32'd1);
    check("post_reset_store_err", 32'(resp_e), 32'd0);
    run(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, e0); idle(1);
    check("illegal_size_err", 32'(resp_e), 32'd1);
    check("illegal_size_latency", resp_cyc - e0 - 1, 32'd0);
    run(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'h0, e0); idle(1);
    check("wrap_word_data", resp_data, 32'h0100FFFE);

    for (int unsigned t = 0; t < 300; t++) begin
      sz = 2'($urandom);
      a  = ($urandom_range(7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(3)) : 32'($urandom_range(63));
      run(1'($urandom), sz, 1'($urandom), a, $urandom, e0);
      if ($urandom_range(3) == 0) idle($urandom_range(3));
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the max cycles spent waiting for mem_ready on one read byte.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: CPU request present.
REQ-005 SHALL have port req_ready, output, 1: unit idle, request accepted when req_valid&req_ready at posedge.
REQ-006 SHALL have port req_write, input, 1: 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed, input, 1: sign-extend load result.
REQ-009 SHALL have port req_addr, input, 32: byte address of first byte.
REQ-010 SHALL have port req_wdata, input, 32: store data, byte 0 = bits 7:0.
REQ-011 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port resp_err, output, 1: qualifies resp_valid; timeout or illegal size.
REQ-013 SHALL have port resp_rdata, output, 32: load result, valid with resp_valid.
REQ-014 SHALL have port mem_addr, output, 32: byte address to memory.
REQ-015 SHALL have port mem_wdata, output, 8: byte to memory data input.
REQ-016 SHALL have port mem_rdata, input, 8: byte from memory data output.
REQ-017 SHALL have port mem_read_en, output, 1: memory read request.
REQ-018 SHALL have port mem_write_en, output, 1: memory write strobe; each cycle high writes one byte.
REQ-019 SHALL have port mem_ready, input, 1: registered one-cycle pulse, read byte valid on mem_rdata.

Function
REQ-020 SHALL implement states IDLE, RD, WR, DONE, ERR; all outputs registered.
REQ-021 SHALL assert req_ready only in IDLE; request fields latched at acceptance edge E0.
REQ-022 SHALL use N = 1/2/4 bytes for size 00/01/10; byte i at address (req_addr + i) mod 2^32, little-endian; no alignment requirement.
REQ-023 SHALL go IDLE->ERR on acceptance with req_size=11, no memory access.
REQ-024 SHALL, for a store, go IDLE->WR: mem_write_en=1 for exactly N consecutive cycles, mem_addr/mem_wdata = byte i in i-th cycle, mem_read_en=0; then DONE.
REQ-025 SHALL, for a load, go IDLE->RD: mem_read_en=1, mem_addr=byte i address held until mem_ready sampled high; on mem_ready capture mem_rdata into byte i, advance i; after byte N-1 go DONE.
REQ-026 SHALL never assert mem_read_en and mem_write_en together.
REQ-027 SHALL, load latency without stalls, capture byte i at edge E0+2(i+1); resp_valid high in cycle after edge E0+2N (load) or E0+N (store).
REQ-028 SHALL zero-extend loads, or sign-extend from bit 8N-1 when req_signed; req_signed ignored for word and stores.
REQ-029 SHALL count cycles in RD per byte (counter cleared on each byte advance); when count reaches TIMEOUT without mem_ready, go ERR.
REQ-030 SHALL treat a read of the same address as the preceding read with no intervening write as a normal request; memory gives no mem_ready, so it terminates via timeout.
REQ-031 SHALL in DONE pulse resp_valid=1, resp_err=0, resp_rdata=result (0 for stores) for one cycle, then IDLE.
REQ-032 SHALL in ERR pulse resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then IDLE.
REQ-033 SHALL drive mem_addr=0, mem_wdata=0, enables 0 whenever not in RD/WR.
REQ-034 SHALL ignore mem_ready outside RD.

Reset
REQ-035 SHALL, with rst high at posedge, enter IDLE: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_read_en=0, mem_write_en=0, counters 0.
REQ-036 SHALL drop any in-flight request on reset with no resp_valid; rst has priority over req_valid in the same cycle.

Verification
REQ-037 Store word 0xDEADBEEF @0x10 -> mem_write_en 4 cycles, addr 0x10..0x13, data EF,BE,AD,DE; resp_valid cycle after E0+4, err=0.
REQ-038 Then load word @0x10 -> resp_rdata 0xDEADBEEF, resp_valid cycle after E0+8.
REQ-039 Memory init mem[i]=i: signed half load @0x80 -> 0xFFFF8180; unsigned byte load @0x7F -> 0x0000007F.
REQ-040 Repeat unsigned byte load @0x7F immediately -> no mem_ready, resp_valid with resp_err=1, resp_rdata=0 after TIMEOUT cycles in RD.
REQ-041 rst high mid word load (after byte 1) -> next cycle enables low, req_ready=1, no resp_valid; new store accepted and completes normally.
REQ-042 req_size=11 load @0x0 -> no mem_read_en/mem_write_en, resp_valid with resp_err=1 one cycle after E0.
